histogram_axi_core: RTL and testbench
=====================================

Name: histogram_axi_core

Overview:
Single-clock, parametrised successor to the video histogram path. Accumulates a per-frame histogram of an N-bit pixel stream into on-chip dual-port RAM with configurable bin count, saturating counters, hazard-free read-modify-write and a total-pixel counter. It sits between the video receive pipeline and the MicroBlaze, and exposes results through an integrated AXI4-Lite read slave.

Parameters:
PIX_W, 8, pixel width in bits
BIN_BITS, 8, log2(number of bins); bin = pixel >> (PIX_W-BIN_BITS); must be <= PIX_W
CNT_W, 24, bin counter width, saturating; must be <= 32
ADDR_BITS, 11, AXI byte address width; must be >= BIN_BITS+3

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset
y_i  in  PIX_W  pixel value
dv_i  in  1  pixel valid
vs_i  in  1  vertical sync; rising edge = frame boundary
cpu_trigger  in  1  start request, single-cycle pulse
cpu_signal_done  out  1  high while histogram complete (DONE)
s_axi_araddr  in  ADDR_BITS  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  OKAY=00, SLVERR=10
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Reset (rst low, async): state IDLE; cpu_signal_done=0, s_axi_arready=0, s_axi_rvalid=0, rdata=0, rresp=00; pixel count=0; overflow=0. RAM contents undefined. Reset mid-frame or mid-CLEAR abandons the operation.
- arready goes 1 on the first clk after reset release.
- FSM: IDLE -(cpu_trigger)-> CLEAR; CLEAR writes 0 to bins 0..2^BIN_BITS-1, one per cycle, and clears pixel count and overflow -> ARMED; ARMED -(vs_i rise)-> ACCUM; ACCUM -(next vs_i rise)-> DONE; DONE -(cpu_trigger)-> CLEAR. cpu_trigger is ignored in CLEAR/ARMED/ACCUM.
- vs_i edge detect uses a 1-cycle registered copy. A vs_i rise coincident with the last CLEAR cycle is missed; ARMED waits for the next rise.
- ACCUM: each cycle with dv_i=1 increments bin[y_i>>(PIX_W-BIN_BITS)] by 1. Pipeline: capture, RAM read, add/write. The written value is visible on the AXI port 3 cycles after the dv_i cycle.
- Back-to-back or alternating hits on the same bin must be forwarded from the add/write stage: N consecutive equal pixels give exactly +N.
- dv_i is ignored outside ACCUM. A pixel accepted on the cycle of the terminating vs_i rise is dropped. The pipeline drains (3 cycles) before cpu_signal_done rises.
- Counter saturates at 2^CNT_W-1 and sets the sticky overflow bit. The pixel count is 32-bit and saturates at 0xFFFFFFFF.
- cpu_signal_done = 1 exactly while in DONE.
- AXI read handshake:
  - AR accepted when arvalid & arready; arready drops the next cycle and stays low until the R handshake completes.
  - rvalid rises 2 cycles after AR acceptance and holds, with rdata/rresp stable, until rready=1.
  - One read outstanding at a time.
- Address map (byte address, word aligned, araddr[1:0] ignored):
  - 0x000 STATUS: [0] done, [1] busy (CLEAR|ARMED|ACCUM), [4:2] state (IDLE=0, CLEAR=1, ARMED=2, ACCUM=3, DONE=4), [8] overflow.
  - 0x004 pixel count.
  - araddr[ADDR_BITS-1]=1: bin region; bin index = araddr[BIN_BITS+1:2]; rdata = zero-extended counter.
  - Bin reads in CLEAR or ACCUM return 0 with SLVERR; otherwise OKAY.
  - Other unmapped addresses return 0 with OKAY.

Optional Feature:
Macro HIST_MINMAX_EN.
- Defined: tracks min and max accepted pixel value per frame. Reset and CLEAR set min=2^PIX_W-1, max=0. Readable at 0x008 (min) and 0x00C (max), zero-extended; stable from DONE.
- Undefined: no tracking logic; 0x008/0x00C read 0 with OKAY.

Test Plan:
- Reset mid-ACCUM with rst low for 3 cycles -> cpu_signal_done=0, rvalid=0; STATUS reads 0x0 (state IDLE) after release.
- Trigger, then frame of 256 pixels with values 0..255 (defaults) -> every bin reads 1, 0x004 reads 256, STATUS=0x011.
- 1000 consecutive dv_i pixels of value 0x7F, plus 1 of 0x80 -> bin 127=1000, bin 128=1; verifies forwarding.
- CNT_W=4, 20 pixels of value 5 -> bin 5 reads 15, STATUS[8]=1.
- AXI read of bin 3 during ACCUM -> rresp=10, rdata=0. Read in DONE with rready held low for 5 cycles -> rvalid and rdata stable throughout, arready low until handshake completes.
- With HIST_MINMAX_EN, frame pixels {40,7,200} -> 0x008=7, 0x00C=200. Without the macro -> both read 0.

Source files
------------

// File: rtl/histogram_axi_core.sv
// Per-frame pixel histogram: saturating bins in dual-port RAM, forwarded read-modify-write,
// pixel counter and an AXI4-Lite read slave. Define HIST_MINMAX_EN for per-frame min/max tracking.
module histogram_axi_core #(
  parameter int PIX_W     = 8,
  parameter int BIN_BITS  = 8,
  parameter int CNT_W     = 24,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     y_i,
  input  logic                 dv_i,
  input  logic                 vs_i,
  input  logic                 cpu_trigger,
  output logic                 cpu_signal_done,
  input  logic [ADDR_BITS-1:0] s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready
);
  localparam int WRD_W = ADDR_BITS - 3;

  // DRAIN is internal only and reports as ACCUM on the status register
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CLEAR = 3'd1, S_ARMED = 3'd2, S_ACCUM = 3'd3, S_DONE = 3'd4, S_DRAIN = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_BITS-1:0] clr_idx_q, clr_idx_d;
  logic [1:0]          drn_q, drn_d;
  logic                vs_q, vs_d;
  logic [2:1]          vld_pipe_q, vld_pipe_d;
  logic [BIN_BITS-1:0] s1_bin_q, s1_bin_d, s2_bin_q, s2_bin_d, fw_bin_q, fw_bin_d;
  logic                fw_vld_q, fw_vld_d;
  logic [CNT_W-1:0]    fw_val_q, fw_val_d;
  logic [31:0]         pix_cnt_q, pix_cnt_d;
  logic                ovf_q, ovf_d;
  logic                ph1_q, ph1_d, ar_bin_q, ar_bin_d, ar_err_q, ar_err_d;
  logic [WRD_W-1:0]    ar_word_q, ar_word_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic [CNT_W-1:0]    mem [2**BIN_BITS];
  logic [CNT_W-1:0]    rd_data, base, sum, wdata;
  logic [BIN_BITS-1:0] waddr, raddr, px_bin;
  logic                we, sat, vs_rise, acc_px, ar_hs, bin_busy, busy;
  logic [2:0]          st_code;
  logic [31:0]         status, min_rd, max_rd;
  logic                unused_bits;

  assign unused_bits = ^{s_axi_araddr[1:0], y_i};
  assign px_bin      = y_i[PIX_W-1 -: BIN_BITS];
  assign vs_rise     = vs_i & ~vs_q;
  assign acc_px      = (state_q == S_ACCUM) & dv_i & ~vs_rise;
  assign ar_hs       = s_axi_arvalid & arready_q;
  assign busy        = state_q inside {S_CLEAR, S_ARMED, S_ACCUM, S_DRAIN};
  assign bin_busy    = state_q inside {S_CLEAR, S_ACCUM, S_DRAIN};
  assign st_code     = (state_q == S_DRAIN) ? 3'd3 : 3'(state_q);
  assign status      = {23'd0, ovf_q, 3'd0, st_code, busy, state_q == S_DONE};

  // The write landing on the same edge as this op's RAM read is not yet visible: forward it
  assign base  = (fw_vld_q && fw_bin_q == s2_bin_q) ? fw_val_q : rd_data;
  assign sat   = &base;
  assign sum   = sat ? base : base + 1'b1;
  assign we    = (state_q == S_CLEAR) | vld_pipe_q[2];
  assign waddr = (state_q == S_CLEAR) ? clr_idx_q : s2_bin_q;
  assign wdata = (state_q == S_CLEAR) ? '0 : sum;
  // AXI bin reads are only allowed when the pipeline is idle, so the port is never contended
  assign raddr = vld_pipe_q[1] ? s1_bin_q : s_axi_araddr[BIN_BITS+1:2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

`ifdef HIST_MINMAX_EN
  logic [PIX_W-1:0] min_q, min_d, max_q, max_d;
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == S_CLEAR) begin
      min_d = '1;
      max_d = '0;
    end else if (acc_px) begin
      if (y_i < min_q) min_d = y_i;
      if (y_i > max_q) max_d = y_i;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign min_rd = 32'(min_q);
  assign max_rd = 32'(max_q);
`else
  assign min_rd = '0;
  assign max_rd = '0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    drn_d     = drn_q;
    case (state_q)
      S_IDLE, S_DONE: if (cpu_trigger) begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (&clr_idx_q) state_d = S_ARMED;
      end
      S_ARMED: if (vs_rise) state_d = S_ACCUM;
      S_ACCUM: if (vs_rise) begin
        state_d = S_DRAIN;
        drn_d   = '0;
      end
      S_DRAIN: begin
        drn_d = drn_q + 2'd1;
        if (drn_q == 2'd2) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vs_d       = vs_i;
    vld_pipe_d = {vld_pipe_q[1], acc_px};
    s1_bin_d   = px_bin;
    s2_bin_d   = s1_bin_q;
    fw_vld_d   = vld_pipe_q[2];
    fw_bin_d   = s2_bin_q;
    fw_val_d   = sum;
    pix_cnt_d  = pix_cnt_q;
    ovf_d      = ovf_q;
    if (state_q == S_CLEAR) begin
      pix_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (acc_px && !(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 32'd1;
      if (vld_pipe_q[2] && sat) ovf_d = 1'b1;
    end
  end

  always_comb begin
    ph1_d     = ar_hs;
    ar_bin_d  = ar_bin_q;
    ar_err_d  = ar_err_q;
    ar_word_d = ar_word_q;
    if (ar_hs) begin
      ar_bin_d  = s_axi_araddr[ADDR_BITS-1];
      ar_err_d  = s_axi_araddr[ADDR_BITS-1] & bin_busy;
      ar_word_d = s_axi_araddr[ADDR_BITS-2:2];
    end
    arready_d = ~(ar_hs | ph1_q | (rvalid_q & ~s_axi_rready));
    rvalid_d  = rvalid_q & ~s_axi_rready;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ph1_q) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_err_q ? 2'b10 : 2'b00;
      if (ar_err_q)      rdata_d = '0;
      else if (ar_bin_q) rdata_d = 32'(rd_data);
      else begin
        case (ar_word_q)
          WRD_W'(0): rdata_d = status;
          WRD_W'(1): rdata_d = pix_cnt_q;
          WRD_W'(2): rdata_d = min_rd;
          WRD_W'(3): rdata_d = max_rd;
          default:   rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      clr_idx_q  <= '0;
      drn_q      <= '0;
      vs_q       <= 1'b0;
      vld_pipe_q <= '0;
      s1_bin_q   <= '0;
      s2_bin_q   <= '0;
      fw_bin_q   <= '0;
      fw_vld_q   <= 1'b0;
      fw_val_q   <= '0;
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      ph1_q      <= 1'b0;
      ar_bin_q   <= 1'b0;
      ar_err_q   <= 1'b0;
      ar_word_q  <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      drn_q      <= drn_d;
      vs_q       <= vs_d;
      vld_pipe_q <= vld_pipe_d;
      s1_bin_q   <= s1_bin_d;
      s2_bin_q   <= s2_bin_d;
      fw_bin_q   <= fw_bin_d;
      fw_vld_q   <= fw_vld_d;
      fw_val_q   <= fw_val_d;
      pix_cnt_q  <= pix_cnt_d;
      ovf_q      <= ovf_d;
      ph1_q      <= ph1_d;
      ar_bin_q   <= ar_bin_d;
      ar_err_q   <= ar_err_d;
      ar_word_q  <= ar_word_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign cpu_signal_done = (state_q == S_DONE);
  assign s_axi_arready   = arready_q;
  assign s_axi_rvalid    = rvalid_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = rresp_q;
endmodule

// File: tb/tb_histogram_axi_core.sv
// Randomized bench for histogram_axi_core: a default instance and a CNT_W=4 instance share stimulus,
// both checked against a per-frame bin/count/min/max model.
module tb_histogram_axi_core;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  y_i = '0;
  logic        dv_i = 1'b0, vs_i = 1'b0, cpu_trigger = 1'b0;
  logic [10:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic        done0, done1, arready0, arready1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;

  int n_chk = 0, n_fail = 0;
  int mb[256];
  int mcnt, mmin, mmax;

  always #5 clk = ~clk;

  histogram_axi_core u_dut0 (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .vs_i(vs_i), .cpu_trigger(cpu_trigger),
    .cpu_signal_done(done0), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(arready0), .s_axi_rdata(rdata0), .s_axi_rresp(rresp0),
    .s_axi_rvalid(rvalid0), .s_axi_rready(s_axi_rready)
  );

  histogram_axi_core #(.CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .vs_i(vs_i), .cpu_trigger(cpu_trigger),
    .cpu_signal_done(done1), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(arready1), .s_axi_rdata(rdata1), .s_axi_rresp(rresp1),
    .s_axi_rvalid(rvalid1), .s_axi_rready(s_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (mb[i]) mb[i] = 0;
    mcnt = 0;
    mmin = 255;
    mmax = 0;
  endtask

  task automatic model_px(input int p);
    mb[p]++;
    mcnt++;
    if (p < mmin) mmin = p;
    if (p > mmax) mmax = p;
  endtask

  task automatic axi_rd(input logic [10:0] a, output logic [31:0] d0, output logic [31:0] d1,
                        output logic [1:0] r0);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!arready0 && n < 20) begin step(); n++; end
    if (n >= 20) chk("ar_timeout", 32'(n), 32'd0);
    step();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!rvalid0 && n < 20) begin step(); n++; end
    if (n >= 20) chk("r_timeout", 32'(n), 32'd0);
    d0 = rdata0;
    d1 = rdata1;
    r0 = rresp0;
    step();
    s_axi_rready = 1'b0;
  endtask

  task automatic arm();
    logic [31:0] d0, d1;
    logic [1:0]  r0;
    cpu_trigger = 1'b1;
    step();
    cpu_trigger = 1'b0;
    model_clear();
    repeat (258) step();
    axi_rd(11'h000, d0, d1, r0);
    chk("armed_status", d0, 32'h0A);
    chk("armed_done", 32'(done0), 32'd0);
  endtask

  task automatic run_frame(input int px[$], input bit gaps, input bit mid_rd);
    logic [31:0] d0, d1;
    logic [1:0]  r0;
    int n;
    vs_i = 1'b1; step();
    vs_i = 1'b0; step();
    foreach (px[i]) begin
      if (mid_rd && i == px.size() / 2) begin
        dv_i = 1'b0;
        axi_rd(11'h40C, d0, d1, r0);
        chk("accum_bin_resp", 32'(r0), 32'd2);
        chk("accum_bin_data", d0, 32'd0);
      end
      y_i  = 8'(px[i]);
      dv_i = 1'b1;
      step();
      model_px(px[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        dv_i = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    // this pixel coincides with the terminating vsync rise and must be dropped
    y_i = 8'($urandom); dv_i = 1'b1; vs_i = 1'b1;
    step();
    dv_i = 1'b0; vs_i = 1'b0;
    n = 0;
    while (!done0 && n < 20) begin step(); n++; end
    chk("done_lat", 32'(n), 32'd3);
  endtask

  task automatic check_frame();
    logic [31:0] d0, d1, emin, emax;
    logic [1:0]  r0;
    bit o1;
    o1 = 1'b0;
    foreach (mb[i]) if (mb[i] > 15) o1 = 1'b1;
`ifdef HIST_MINMAX_EN
    emin = 32'(mmin);
    emax = 32'(mmax);
`else
    emin = 32'd0;
    emax = 32'd0;
`endif
    chk("done1", 32'(done1), 32'd1);
    axi_rd(11'h000, d0, d1, r0);
    chk("status0", d0, 32'h11);
    chk("status1", d1, 32'h11 | (32'(o1) << 8));
    chk("status_resp", 32'(r0), 32'd0);
    axi_rd(11'h004, d0, d1, r0);
    chk("count0", d0, 32'(mcnt));
    chk("count1", d1, 32'(mcnt));
    axi_rd(11'h008, d0, d1, r0);
    chk("min", d0, emin);
    axi_rd(11'h00C, d0, d1, r0);
    chk("max", d0, emax);
    chk("max_resp", 32'(r0), 32'd0);
    axi_rd(11'h010, d0, d1, r0);
    chk("unmapped", d0, 32'd0);
    for (int b = 0; b < 256; b++) begin
      axi_rd(11'h400 + 11'(b * 4), d0, d1, r0);
      chk($sformatf("bin%0d_w24", b), d0, 32'(mb[b]));
      chk($sformatf("bin%0d_w4", b), d1, 32'(mb[b] > 15 ? 15 : mb[b]));
      chk($sformatf("bin%0d_resp", b), 32'(r0), 32'd0);
    end
  endtask

  task automatic hold_test();
    int n, lat;
    s_axi_araddr  = 11'h414;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!arready0 && n < 20) begin step(); n++; end
    step();
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!rvalid0 && lat < 20) begin step(); lat++; end
    chk("r_lat", 32'(lat), 32'd2);
    repeat (5) begin
      chk("hold_rvalid", 32'(rvalid0), 32'd1);
      chk("hold_rdata", rdata0, 32'(mb[5]));
      chk("hold_arready", 32'(arready0), 32'd0);
      chk("hold_arready1", 32'(arready1), 32'd0);
      step();
    end
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
    chk("post_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
    chk("post_arready", 32'(arready0), 32'd1);
  endtask

  initial begin
    int q[$];
    logic [31:0] d0, d1;
    logic [1:0]  r0;
    model_clear();
    repeat (3) step();
    chk("rst_arready", 32'(arready0), 32'd0);
    chk("rst_rvalid", 32'(rvalid0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    rst = 1'b1;
    step();
    chk("arready_after_rst", 32'(arready0), 32'd1);
    axi_rd(11'h000, d0, d1, r0);
    chk("rst_status", d0, 32'd0);
    axi_rd(11'h004, d0, d1, r0);
    chk("rst_count", d0, 32'd0);

    arm();
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(i);
    run_frame(q, 1'b0, 1'b0);
    check_frame();

    arm();
    q.delete();
    repeat (1000) q.push_back(8'h7F);
    q.push_back(8'h80);
    run_frame(q, 1'b0, 1'b0);
    check_frame();

    arm();
    q.delete();
    repeat (20) q.push_back(5);
    run_frame(q, 1'b1, 1'b0);
    check_frame();

    arm();
    q = '{40, 7, 200};
    run_frame(q, 1'b1, 1'b0);
    check_frame();

    for (int f = 0; f < 3; f++) begin
      arm();
      q.delete();
      repeat ($urandom_range(200, 400))
        q.push_back(f == 1 ? int'($urandom_range(0, 255)) : int'($urandom_range(60, 63)));
      run_frame(q, 1'b1, f == 0);
      check_frame();
    end
    hold_test();

    arm();
    vs_i = 1'b1; step();
    vs_i = 1'b0; step();
    repeat (10) begin y_i = 8'($urandom); dv_i = 1'b1; step(); end
    dv_i = 1'b0;
    rst  = 1'b0;
    repeat (3) begin
      step();
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_rvalid", 32'(rvalid0), 32'd0);
    end
    rst = 1'b1;
    step();
    axi_rd(11'h000, d0, d1, r0);
    chk("midrst_status", d0, 32'd0);

    arm();
    q.delete();
    repeat ($urandom_range(100, 300)) q.push_back(int'($urandom_range(0, 255)));
    run_frame(q, 1'b1, 1'b0);
    check_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
